// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: issue/writeback scheduler for ALU, shifter and pipelined MADD engines
module fu_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int MADD_LAT = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             IN_VALID,
  input  logic [4:0]       IN_INST,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             IN_READY,
  output logic             EN_ALU,
  output logic             EN_BS,
  output logic             EN_MADD,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [TAG_W-1:0] RES_TAG,
  output logic [1:0]       RES_SEL,
  output logic [3:0]       INFLIGHT,
  output logic [CNT_W-1:0] STALL_CNT
);
  localparam int L = MADD_LAT - 1;
  logic [L:1] m_v;
  logic [TAG_W-1:0] m_t [1:L];
  logic is_bs, is_alu, is_madd, freeze, hazard, acc, hs;
  always_comb begin
    is_bs = !IN_INST[3];
    is_alu = !IN_INST[4] & IN_INST[3];
    is_madd = IN_INST[4] & IN_INST[3];
    freeze = RES_VALID & !RES_READY;
    hazard = !is_madd & m_v[L];
    IN_READY = !RESET & !freeze & !hazard;
    acc = IN_VALID & IN_READY;
    EN_ALU = acc & is_alu;
    EN_BS = acc & is_bs;
    EN_MADD = !RESET & !freeze & ((acc & is_madd) | (|m_v));
    hs = RES_VALID & RES_READY;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      m_v <= '0;
      RES_VALID <= 1'b0;
      RES_TAG <= '0;
      RES_SEL <= 2'b00;
      INFLIGHT <= '0;
      STALL_CNT <= '0;
    end else begin
      if (!freeze) begin
        m_v[1] <= acc & is_madd;
        m_t[1] <= IN_TAG;
        for (int k = 2; k <= L; k++) begin
          m_v[k] <= m_v[k-1];
          m_t[k] <= m_t[k-1];
        end
        if (EN_ALU | EN_BS) begin
          RES_VALID <= 1'b1;
          RES_TAG <= IN_TAG;
          RES_SEL <= EN_ALU ? 2'b01 : 2'b00;
        end else if (m_v[L]) begin
          RES_VALID <= 1'b1;
          RES_TAG <= m_t[L];
          RES_SEL <= 2'b10;
        end else begin
          RES_VALID <= 1'b0;
        end
      end
      INFLIGHT <= INFLIGHT + 4'(acc) - 4'(hs);
      if (IN_VALID & !freeze & hazard & !(&STALL_CNT)) STALL_CNT <= STALL_CNT + 1'b1;
    end
  end
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: scoreboard bench for fu_issue_ctrl with directed vectors
module tb_fu_issue_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, res_ready = 1'b1;
  logic [4:0] in_inst = '0;
  logic [3:0] in_tag = '0;
  logic in_ready, en_alu, en_bs, en_madd, res_valid;
  logic [3:0] res_tag, inflight;
  logic [1:0] res_sel;
  logic [15:0] stall_cnt;
  logic [5:0] sb [$];
  int checks = 0, passes = 0;
  localparam logic [4:0] ALU = 5'b01000, BS = 5'b00000, MADD = 5'b11000;
  fu_issue_ctrl dut (
    .CLOCK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_INST(in_inst), .IN_TAG(in_tag),
    .IN_READY(in_ready), .EN_ALU(en_alu), .EN_BS(en_bs), .EN_MADD(en_madd),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_TAG(res_tag), .RES_SEL(res_sel),
    .INFLIGHT(inflight), .STALL_CNT(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
  endtask
  task automatic drv(input logic v, input logic [4:0] inst, input logic [3:0] tag, input logic rr);
    in_valid = v;
    in_inst = inst;
    in_tag = tag;
    res_ready = rr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (res_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result got tag %0h sel %0b expected none", res_tag, res_sel);
      end else begin
        chk("res_tag", res_tag, sb[0][5:2]);
        chk("res_sel", res_sel, sb[0][1:0]);
        if (res_ready) void'(sb.pop_front());
      end
    end
    if (en_alu || en_bs) chk("no_collision", dut.m_v[2], 0);
  end
  initial begin
    drv(1, ALU, 4'd1, 1);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_en_alu", en_alu, 0);
    tick();
    drv(0, BS, 0, 1);
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_sel", res_sel, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_en_madd", en_madd, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_inflight", inflight, 0);
    tick();
    drv(1, ALU, 4'd5, 1);
    sb.push_back({4'd5, 2'b01});
    @(negedge clk);
    chk("t2_in_ready", in_ready, 1);
    chk("t2_en_alu", en_alu, 1);
    chk("t2_en_bs", en_bs, 0);
    chk("t2_en_madd", en_madd, 0);
    tick();
    drv(0, BS, 0, 1);
    @(negedge clk);
    chk("t2_c1_valid", res_valid, 1);
    chk("t2_c1_inflight", inflight, 1);
    tick();
    @(negedge clk);
    chk("t2_c2_valid", res_valid, 0);
    chk("t2_c2_inflight", inflight, 0);
    tick();
    drv(1, MADD, 4'd2, 1);
    @(negedge clk);
    chk("t3_c0_en_madd", en_madd, 1);
    tick();
    drv(1, ALU, 4'd3, 1);
    sb.push_back({4'd3, 2'b01});
    sb.push_back({4'd2, 2'b10});
    @(negedge clk);
    chk("t3_c1_in_ready", in_ready, 1);
    chk("t3_c1_en_alu", en_alu, 1);
    tick();
    drv(1, BS, 4'd4, 1);
    @(negedge clk);
    chk("t3_c2_in_ready", in_ready, 0);
    chk("t3_c2_en_bs", en_bs, 0);
    chk("t3_c2_sel", res_sel, 2'b01);
    chk("t3_c2_inflight", inflight, 2);
    tick();
    sb.push_back({4'd4, 2'b00});
    @(negedge clk);
    chk("t3_c3_in_ready", in_ready, 1);
    chk("t3_c3_en_bs", en_bs, 1);
    chk("t3_c3_stall", stall_cnt, 1);
    chk("t3_c3_sel", res_sel, 2'b10);
    tick();
    drv(0, BS, 0, 1);
    @(negedge clk);
    chk("t3_c4_valid", res_valid, 1);
    chk("t3_c4_sel", res_sel, 2'b00);
    tick();
    @(negedge clk);
    chk("t3_c5_valid", res_valid, 0);
    chk("t3_c5_inflight", inflight, 0);
    tick();
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        drv(1, MADD, 4'(c + 1), 1);
        sb.push_back({4'(c + 1), 2'b10});
      end else drv(0, BS, 0, 1);
      @(negedge clk);
      chk($sformatf("t4_c%0d_en_madd", c), en_madd, c < 5);
      chk($sformatf("t4_c%0d_valid", c), res_valid, c >= 3 && c <= 5);
      if (c == 3) chk("t4_inflight_peak", inflight, 3);
      tick();
    end
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        drv(1, MADD, 4'(c + 1), 1);
        sb.push_back({4'(c + 1), 2'b10});
      end else drv(0, BS, 0, !(c == 3 || c == 4));
      @(negedge clk);
      chk($sformatf("t5_c%0d_en_madd", c), en_madd, c < 3 || c == 5 || c == 6);
      chk($sformatf("t5_c%0d_valid", c), res_valid, c >= 3 && c <= 7);
      if (c == 3 || c == 4) chk($sformatf("t5_c%0d_in_ready", c), in_ready, 0);
      if (c >= 3 && c <= 5) chk($sformatf("t5_c%0d_tag", c), res_tag, 1);
      if (c == 6) chk("t5_c6_tag", res_tag, 2);
      if (c == 7) chk("t5_c7_tag", res_tag, 3);
      tick();
    end
    drv(1, MADD, 4'd7, 1);
    tick();
    drv(1, MADD, 4'd8, 1);
    tick();
    drv(0, BS, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(1, ALU, 4'd9, 1);
    sb.push_back({4'd9, 2'b01});
    @(negedge clk);
    chk("t6_c3_inflight", inflight, 0);
    chk("t6_c3_stall", stall_cnt, 0);
    chk("t6_c3_valid", res_valid, 0);
    chk("t6_c3_in_ready", in_ready, 1);
    tick();
    drv(0, BS, 0, 1);
    @(negedge clk);
    chk("t6_c4_valid", res_valid, 1);
    chk("t6_c4_tag", res_tag, 9);
    tick();
    for (int c = 5; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("t6_c%0d_valid", c), res_valid, 0);
      tick();
    end
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
